// File: rtl/axis_tap_fifo.sv
// Passive AXI4-Stream tap with a frame buffer: snooped beats are queued and replayed on m_axis.
// Overflow either truncates the frame with a bad-frame marker or drops the whole frame.
module axis_tap_fifo #(
  parameter int                    DATA_WIDTH           = 8,
  parameter bit                    KEEP_ENABLE          = (DATA_WIDTH > 8),
  parameter int                    KEEP_WIDTH           = (DATA_WIDTH + 7) / 8,
  parameter bit                    ID_ENABLE            = 1'b0,
  parameter int                    ID_WIDTH             = 8,
  parameter bit                    DEST_ENABLE          = 1'b0,
  parameter int                    DEST_WIDTH           = 8,
  parameter bit                    USER_ENABLE          = 1'b1,
  parameter int                    USER_WIDTH           = 1,
  parameter logic [USER_WIDTH-1:0] USER_BAD_FRAME_VALUE = 1'b1,
  parameter logic [USER_WIDTH-1:0] USER_BAD_FRAME_MASK  = 1'b1,
  parameter int                    DEPTH                = 16,
  parameter bit                    DROP_MODE            = 1'b0,
  parameter int                    COUNT_WIDTH          = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_WIDTH-1:0]  tap_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]  tap_axis_tkeep,
  input  logic                   tap_axis_tvalid,
  input  logic                   tap_axis_tready,
  input  logic                   tap_axis_tlast,
  input  logic [ID_WIDTH-1:0]    tap_axis_tid,
  input  logic [DEST_WIDTH-1:0]  tap_axis_tdest,
  input  logic [USER_WIDTH-1:0]  tap_axis_tuser,
  output logic [DATA_WIDTH-1:0]  m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]  m_axis_tkeep,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tlast,
  output logic [ID_WIDTH-1:0]    m_axis_tid,
  output logic [DEST_WIDTH-1:0]  m_axis_tdest,
  output logic [USER_WIDTH-1:0]  m_axis_tuser,
  input  logic                   enable,
  output logic [COUNT_WIDTH-1:0] status_frame_count,
  output logic [COUNT_WIDTH-1:0] status_trunc_count,
  output logic [COUNT_WIDTH-1:0] status_drop_count,
  output logic                   status_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int KO = DATA_WIDTH;
  localparam int IO = KO + KEEP_WIDTH;
  localparam int DO = IO + ID_WIDTH;
  localparam int UO = DO + DEST_WIDTH;
  localparam int LO = UO + USER_WIDTH;
  localparam int WW = LO + 1;
  localparam logic [AW:0]          DepthP = (AW + 1)'(DEPTH);
  localparam logic [AW:0]          PtrOne = (AW + 1)'(1);
  localparam logic [COUNT_WIDTH-1:0] CntOne = COUNT_WIDTH'(1);

  typedef enum logic [1:0] {StIdle, StCapture, StDiscard} state_e;

  state_e                 state_q, state_d;
  logic [WW-1:0]          mem_q [DEPTH];
  logic [AW:0]            wr_ptr_q, wr_ptr_d;   // speculative in drop mode
  logic [AW:0]            cm_ptr_q, cm_ptr_d;   // words below this are readable
  logic [AW:0]            rd_ptr_q, rd_ptr_d;
  logic                   out_valid_q, out_valid_d;
  logic [WW-1:0]          out_word_q, out_word_d;
  logic [COUNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
  logic [COUNT_WIDTH-1:0] trunc_cnt_q, trunc_cnt_d;
  logic [COUNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
  logic                   ovf_q, ovf_d;

  logic                   beat, take, wr_en;
  logic [AW:0]            used, free;
  logic [WW-1:0]          beat_word, marker_word, wr_word;
  logic [KEEP_WIDTH-1:0]  keep_in;
  logic [ID_WIDTH-1:0]    id_in;
  logic [DEST_WIDTH-1:0]  dest_in;
  logic [USER_WIDTH-1:0]  user_in, user_bad;

  assign beat = tap_axis_tvalid && tap_axis_tready;
  assign take = beat && ((state_q == StCapture) || ((state_q == StIdle) && enable));
  // The slot held by the output register stays occupied until it is handed off.
  assign used = wr_ptr_q - rd_ptr_q + {{AW{1'b0}}, out_valid_q};
  assign free = DepthP - used;

  assign keep_in  = KEEP_ENABLE ? tap_axis_tkeep : '1;
  assign id_in    = ID_ENABLE ? tap_axis_tid : '0;
  assign dest_in  = DEST_ENABLE ? tap_axis_tdest : '0;
  assign user_in  = USER_ENABLE ? tap_axis_tuser : '0;
  assign user_bad = USER_ENABLE ?
                    ((tap_axis_tuser & ~USER_BAD_FRAME_MASK) |
                     (USER_BAD_FRAME_VALUE & USER_BAD_FRAME_MASK)) : '0;

  assign beat_word   = {tap_axis_tlast, user_in, dest_in, id_in, keep_in, tap_axis_tdata};
  assign marker_word = {1'b1, user_bad, dest_in, id_in, KEEP_WIDTH'(1), DATA_WIDTH'(0)};

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    cm_ptr_d    = cm_ptr_q;
    wr_en       = 1'b0;
    wr_word     = beat_word;
    frame_cnt_d = frame_cnt_q;
    trunc_cnt_d = trunc_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    ovf_d       = 1'b0;
    if (beat) begin
      if (tap_axis_tlast) begin
        state_d = StIdle;
      end else if (state_q == StIdle) begin
        state_d = enable ? StCapture : StDiscard;
      end
      if (take) begin
        if (free == '0) begin
          wr_ptr_d   = cm_ptr_q;
          drop_cnt_d = drop_cnt_q + CntOne;
          ovf_d      = 1'b1;
          if (!tap_axis_tlast) state_d = StDiscard;
        end else if (!DROP_MODE && !tap_axis_tlast && (free == PtrOne)) begin
          wr_en       = 1'b1;
          wr_word     = marker_word;
          wr_ptr_d    = wr_ptr_q + PtrOne;
          cm_ptr_d    = wr_ptr_q + PtrOne;
          trunc_cnt_d = trunc_cnt_q + CntOne;
          ovf_d       = 1'b1;
          state_d     = StDiscard;
        end else begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + PtrOne;
          if (!DROP_MODE || tap_axis_tlast) cm_ptr_d = wr_ptr_q + PtrOne;
          if (tap_axis_tlast) frame_cnt_d = frame_cnt_q + CntOne;
        end
      end
    end
  end

  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    out_valid_d = out_valid_q;
    out_word_d  = out_word_q;
    if (!out_valid_q || m_axis_tready) begin
      out_valid_d = (cm_ptr_q != rd_ptr_q);
      if (cm_ptr_q != rd_ptr_q) begin
        out_word_d = mem_q[rd_ptr_q[AW-1:0]];
        rd_ptr_d   = rd_ptr_q + PtrOne;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= wr_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      cm_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_word_q  <= '0;
      frame_cnt_q <= '0;
      trunc_cnt_q <= '0;
      drop_cnt_q  <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      cm_ptr_q    <= cm_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      out_valid_q <= out_valid_d;
      out_word_q  <= out_word_d;
      frame_cnt_q <= frame_cnt_d;
      trunc_cnt_q <= trunc_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      ovf_q       <= ovf_d;
    end
  end

  assign m_axis_tvalid      = out_valid_q;
  assign m_axis_tdata       = out_word_q[KO-1:0];
  assign m_axis_tkeep       = out_word_q[IO-1:KO];
  assign m_axis_tid         = out_word_q[DO-1:IO];
  assign m_axis_tdest       = out_word_q[UO-1:DO];
  assign m_axis_tuser       = out_word_q[LO-1:UO];
  assign m_axis_tlast       = out_word_q[LO];
  assign status_frame_count = frame_cnt_q;
  assign status_trunc_count = trunc_cnt_q;
  assign status_drop_count  = drop_cnt_q;
  assign status_overflow    = ovf_q;

endmodule

// File: tb/tb_axis_tap_fifo.sv
// Directed bench: one truncate-mode and one drop-mode tap share the monitored link.
module tb_axis_tap_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tap_tdata;
  logic [0:0] tap_tkeep;
  logic       tap_tvalid, tap_tready, tap_tlast;
  logic [7:0] tap_tid, tap_tdest;
  logic [0:0] tap_tuser;
  logic       enable, rdy_t, rdy_d;

  logic [7:0]  t_tdata, d_tdata, t_tid, d_tid, t_tdest, d_tdest;
  logic [0:0]  t_tkeep, d_tkeep, t_tuser, d_tuser;
  logic        t_tvalid, d_tvalid, t_tlast, d_tlast, t_ovf, d_ovf;
  logic [15:0] t_fc, t_tc, t_dc, d_fc, d_tc, d_dc;

  int n_chk = 0;
  int n_bad = 0;
  int cyc = 0;
  int beat1_cyc, first_t, first_d, ovf_t, ovf_d;
  logic [10:0] qt[$];
  logic [10:0] qd[$];
  logic [10:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  axis_tap_fifo #(.DROP_MODE(1'b0)) dut_t (
    .clk(clk), .rst(rst),
    .tap_axis_tdata(tap_tdata), .tap_axis_tkeep(tap_tkeep), .tap_axis_tvalid(tap_tvalid),
    .tap_axis_tready(tap_tready), .tap_axis_tlast(tap_tlast), .tap_axis_tid(tap_tid),
    .tap_axis_tdest(tap_tdest), .tap_axis_tuser(tap_tuser),
    .m_axis_tdata(t_tdata), .m_axis_tkeep(t_tkeep), .m_axis_tvalid(t_tvalid),
    .m_axis_tready(rdy_t), .m_axis_tlast(t_tlast), .m_axis_tid(t_tid),
    .m_axis_tdest(t_tdest), .m_axis_tuser(t_tuser), .enable(enable),
    .status_frame_count(t_fc), .status_trunc_count(t_tc), .status_drop_count(t_dc),
    .status_overflow(t_ovf)
  );

  axis_tap_fifo #(.DROP_MODE(1'b1)) dut_d (
    .clk(clk), .rst(rst),
    .tap_axis_tdata(tap_tdata), .tap_axis_tkeep(tap_tkeep), .tap_axis_tvalid(tap_tvalid),
    .tap_axis_tready(tap_tready), .tap_axis_tlast(tap_tlast), .tap_axis_tid(tap_tid),
    .tap_axis_tdest(tap_tdest), .tap_axis_tuser(tap_tuser),
    .m_axis_tdata(d_tdata), .m_axis_tkeep(d_tkeep), .m_axis_tvalid(d_tvalid),
    .m_axis_tready(rdy_d), .m_axis_tlast(d_tlast), .m_axis_tid(d_tid),
    .m_axis_tdest(d_tdest), .m_axis_tuser(d_tuser), .enable(enable),
    .status_frame_count(d_fc), .status_trunc_count(d_tc), .status_drop_count(d_dc),
    .status_overflow(d_ovf)
  );

  // Inputs change just after posedge, so the negedge view is the handshake of the next edge.
  always @(negedge clk) begin
    if (t_tvalid && rdy_t) qt.push_back({t_tlast, t_tuser, t_tkeep, t_tdata});
    if (d_tvalid && rdy_d) qd.push_back({d_tlast, d_tuser, d_tkeep, d_tdata});
    if (t_tvalid && first_t < 0) first_t = cyc;
    if (d_tvalid && first_d < 0) first_d = cyc;
    if (t_ovf) ovf_t++;
    if (d_ovf) ovf_d++;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] mk(input logic last, input logic user, input logic [7:0] data);
    return {last, user, 1'b1, data};
  endfunction

  task automatic clear_mon();
    qt.delete();
    qd.delete();
    first_t = -1;
    first_d = -1;
    ovf_t = 0;
    ovf_d = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    clear_mon();
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // en_on: beat index (1-based) before which enable is raised; 0 leaves enable alone.
  task automatic send_beats(input int n, input logic [7:0] base, input bit last_at_end,
                            input int en_on);
    beat1_cyc = cyc;
    for (int i = 0; i < n; i++) begin
      if (en_on == i + 1) enable = 1'b1;
      tap_tvalid = 1'b1;
      tap_tdata  = base + 8'(i);
      tap_tlast  = last_at_end && (i == n - 1);
      @(posedge clk);
      #1;
    end
    tap_tvalid = 1'b0;
    tap_tlast  = 1'b0;
  endtask

  task automatic check_stream(input string tag, input bit use_d);
    logic [10:0] got[$];
    if (use_d) got = qd;
    else got = qt;
    check_val({tag, "_len"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      check_val($sformatf("%s[%0d]", tag, i), 32'(got[i]), 32'(exp_q[i]));
  endtask

  initial begin
    rst = 1'b1;
    tap_tdata = '0; tap_tkeep = 1'b1; tap_tvalid = 1'b0; tap_tready = 1'b1; tap_tlast = 1'b0;
    tap_tid = '0; tap_tdest = '0; tap_tuser = '0;
    enable = 1'b1; rdy_t = 1'b1; rdy_d = 1'b1;
    do_reset();

    check_val("rst_tvalid_t", 32'(t_tvalid), 0);
    check_val("rst_tvalid_d", 32'(d_tvalid), 0);
    check_val("rst_cnt_t", {t_fc, t_tc}, 0);
    check_val("rst_drop_t", 32'(t_dc), 0);
    check_val("rst_cnt_d", {d_fc, d_tc}, 0);
    check_val("rst_drop_d", 32'(d_dc), 0);
    check_val("rst_ovf", {t_ovf, d_ovf}, 0);

    // Valid without ready is not a beat.
    tap_tvalid = 1'b1; tap_tready = 1'b0; tap_tdata = 8'hee; tap_tlast = 1'b1;
    wait_cyc(2);
    tap_tvalid = 1'b0; tap_tready = 1'b1; tap_tlast = 1'b0;

    // 10-beat frame, ready high on both.
    send_beats(10, 8'd1, 1'b1, 0);
    wait_cyc(16);
    exp_q.delete();
    for (int i = 1; i <= 10; i++) exp_q.push_back(mk(i == 10, 1'b0, 8'(i)));
    check_stream("t1_t", 1'b0);
    check_stream("t1_d", 1'b1);
    check_val("t1_lat_t", first_t - beat1_cyc, 2);
    check_val("t1_lat_d", first_d - (beat1_cyc + 9), 2);
    check_val("t1_frames_t", 32'(t_fc), 1);
    check_val("t1_frames_d", 32'(d_fc), 1);

    // 20-beat frame: truncate with ready low, drop mode with ready high.
    do_reset();
    rdy_t = 1'b0; rdy_d = 1'b1;
    send_beats(20, 8'd1, 1'b1, 0);
    rdy_t = 1'b1;
    wait_cyc(25);
    exp_q.delete();
    for (int i = 1; i <= 15; i++) exp_q.push_back(mk(1'b0, 1'b0, 8'(i)));
    exp_q.push_back(mk(1'b1, 1'b1, 8'h00));
    check_stream("t2_t", 1'b0);
    check_val("t2_trunc_t", 32'(t_tc), 1);
    check_val("t2_frames_t", 32'(t_fc), 0);
    check_val("t2_drop_t", 32'(t_dc), 0);
    check_val("t2_ovf_t", ovf_t, 1);
    exp_q.delete();
    check_stream("t2_d", 1'b1);
    check_val("t2_drop_d", 32'(d_dc), 1);
    check_val("t2_frames_d", 32'(d_fc), 0);
    check_val("t2_ovf_d", ovf_d, 1);

    // 8-beat then 12-beat frame with both readies low.
    do_reset();
    rdy_t = 1'b0; rdy_d = 1'b0;
    send_beats(8, 8'h21, 1'b1, 0);
    send_beats(12, 8'h31, 1'b1, 0);
    rdy_t = 1'b1; rdy_d = 1'b1;
    wait_cyc(30);
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(mk(i == 7, 1'b0, 8'h21 + 8'(i)));
    check_stream("t3_d", 1'b1);
    check_val("t3_drop_d", 32'(d_dc), 1);
    check_val("t3_frames_d", 32'(d_fc), 1);
    for (int i = 0; i < 7; i++) exp_q.push_back(mk(1'b0, 1'b0, 8'h31 + 8'(i)));
    exp_q.push_back(mk(1'b1, 1'b1, 8'h00));
    check_stream("t3_t", 1'b0);
    check_val("t3_trunc_t", 32'(t_tc), 1);
    check_val("t3_frames_t", 32'(t_fc), 1);

    // Frame A starts disabled; enable rises mid-frame; frame B is captured.
    do_reset();
    enable = 1'b0;
    send_beats(5, 8'h41, 1'b1, 3);
    send_beats(3, 8'h51, 1'b1, 0);
    wait_cyc(20);
    exp_q.delete();
    for (int i = 0; i < 3; i++) exp_q.push_back(mk(i == 2, 1'b0, 8'h51 + 8'(i)));
    check_stream("t5_t", 1'b0);
    check_stream("t5_d", 1'b1);
    check_val("t5_frames_t", 32'(t_fc), 1);
    check_val("t5_drop_t", 32'(t_dc), 0);

    // Reset after beat 4 of a 10-beat frame.
    do_reset();
    send_beats(4, 8'd1, 1'b0, 0);
    rst = 1'b1;
    wait_cyc(1);
    rst = 1'b0;
    check_val("t6_tvalid_t", 32'(t_tvalid), 0);
    check_val("t6_tvalid_d", 32'(d_tvalid), 0);
    clear_mon();
    send_beats(6, 8'd5, 1'b1, 0);
    send_beats(3, 8'h61, 1'b1, 0);
    wait_cyc(20);
    exp_q.delete();
    for (int i = 5; i <= 10; i++) exp_q.push_back(mk(i == 10, 1'b0, 8'(i)));
    for (int i = 0; i < 3; i++) exp_q.push_back(mk(i == 2, 1'b0, 8'h61 + 8'(i)));
    check_stream("t6_t", 1'b0);
    check_stream("t6_d", 1'b1);
    check_val("t6_frames_t", 32'(t_fc), 2);
    check_val("t6_frames_d", 32'(d_fc), 2);
    check_val("t6_trunc_t", 32'(t_tc), 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
